// File: rtl/c_join16_pmp.sv
// 16-way drive/free join: collects one drive per enabled lane, fires downstream, returns frees.
// Optional watchdog built when JOIN_TIMEOUT_EN is defined; otherwise o_timeout is tied to 0.
module c_join16_pmp #(
  parameter logic [15:0] LANE_EN        = 16'hFFFF,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] i_drive,
  output logic [15:0] o_free,
  output logic        o_driveNext,
  input  logic        i_freeNext,
  output logic        o_fire,
  output logic [15:0] o_arrived,
  output logic        o_dup_err,
  output logic        o_timeout,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FIRE    = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  if (LANE_EN == 16'h0000) begin : g_badLaneEn
    $error("LANE_EN must be nonzero");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_badTimeout
    $error("TIMEOUT_CYCLES must be in 2..65535");
  end

  // Handshake: i_drive[k] and i_freeNext are single-cycle pulses sampled on the rising edge;
  // o_driveNext, o_free and o_fire are single-cycle registered pulses. A lane may drive once
  // per round and only while the join is collecting; anything else is dropped and flagged.
  state_t      state;
  logic [15:0] arr;
  logic [15:0] enDrive;
  logic [15:0] arrNext;
  logic        dupHit;

  always_comb begin
    enDrive = i_drive & LANE_EN;
    arrNext = arr | enDrive;
    dupHit  = (state == COLLECT) ? |(enDrive & arr) : |enDrive;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= COLLECT;
      arr         <= 16'h0000;
      o_driveNext <= 1'b0;
      o_free      <= 16'h0000;
      o_fire      <= 1'b0;
      o_dup_err   <= 1'b0;
    end else begin
      o_driveNext <= 1'b0;
      o_free      <= 16'h0000;
      o_fire      <= 1'b0;
      if (dupHit) o_dup_err <= 1'b1;
      case (state)
        COLLECT: begin
          arr <= arrNext;
          if (arrNext == LANE_EN) begin
            state       <= FIRE;
            o_driveNext <= 1'b1;
          end
        end
        FIRE, WAIT: begin
          if (i_freeNext) begin
            state  <= RELEASE;
            o_free <= LANE_EN;
            o_fire <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        RELEASE: begin
          arr   <= 16'h0000;
          state <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign o_arrived = arr;
  assign o_state   = state;

`ifdef JOIN_TIMEOUT_EN
  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

  logic [15:0] cnt;
  logic [15:0] cntNext;
  logic [15:0] cntInc;

  always_comb begin
    cntInc  = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    cntNext = cnt;
    case (state)
      COLLECT: cntNext = (arr == 16'h0000) ? 16'd0 : cntInc;
      FIRE:    cntNext = i_freeNext ? 16'd0 : cnt;
      WAIT:    cntNext = i_freeNext ? 16'd0 : cntInc;
      default: cntNext = cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= 16'd0;
      o_timeout <= 1'b0;
    end else begin
      cnt <= cntNext;
      if (cntNext >= TimeoutLimit) o_timeout <= 1'b1;
    end
  end
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_c_join16_pmp.sv
// Directed bench for c_join16_pmp: full-width join, a partial-lane join and a watchdog instance.
module tb_c_join16_pmp;

`ifdef JOIN_TIMEOUT_EN
  localparam logic TO_EXP = 1'b1;
`else
  localparam logic TO_EXP = 1'b0;
`endif

  logic clk;
  logic rstn;

  logic [15:0] d0, d1, d2;
  logic        f0, f1, f2;
  logic [15:0] free0, free1, free2;
  logic        dn0, dn1, dn2;
  logic        fire0, fire1, fire2;
  logic [15:0] arr0, arr1, arr2;
  logic        dup0, dup1, dup2;
  logic        to0, to1, to2;
  logic [1:0]  st0, st1, st2;

  int checks;
  int errors;

  c_join16_pmp u0 (
    .clk(clk), .rstn(rstn), .i_drive(d0), .o_free(free0), .o_driveNext(dn0),
    .i_freeNext(f0), .o_fire(fire0), .o_arrived(arr0), .o_dup_err(dup0),
    .o_timeout(to0), .o_state(st0)
  );

  c_join16_pmp #(.LANE_EN(16'h00F0)) u1 (
    .clk(clk), .rstn(rstn), .i_drive(d1), .o_free(free1), .o_driveNext(dn1),
    .i_freeNext(f1), .o_fire(fire1), .o_arrived(arr1), .o_dup_err(dup1),
    .o_timeout(to1), .o_state(st1)
  );

  c_join16_pmp #(.TIMEOUT_CYCLES(20)) u2 (
    .clk(clk), .rstn(rstn), .i_drive(d2), .o_free(free2), .o_driveNext(dn2),
    .i_freeNext(f2), .o_fire(fire2), .o_arrived(arr2), .o_dup_err(dup2),
    .o_timeout(to2), .o_state(st2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    d0 = '0; d1 = '0; d2 = '0;
    f0 = 1'b0; f1 = 1'b0; f2 = 1'b0;
    tick(); tick();
    checks++; if ({free0, dn0, fire0, arr0, dup0, to0} !== 35'd0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", {free0, dn0, fire0, arr0, dup0, to0});
    end
    checks++; if (st0 !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", st0); end
    rstn = 1'b1;
    tick();
    checks++; if ({free0, dn0, fire0, arr0, dup0, to0} !== 35'd0) begin
      errors++; $display("FAIL post_reset_outputs got=%h exp=0", {free0, dn0, fire0, arr0, dup0, to0});
    end
  endtask

  task automatic test_staggered;
    int pulses;
    logic [15:0] expArr;
    pulses = 0;
    expArr = '0;
    for (int i = 0; i < 16; i++) begin
      d0 = 16'h1 << i;
      expArr = expArr | (16'h1 << i);
      tick();
      pulses += int'(dn0);
      checks++; if (arr0 !== expArr) begin
        errors++; $display("FAIL stag_arrived lane=%0d got=%h exp=%h", i, arr0, expArr);
      end
    end
    d0 = '0;
    checks++; if (pulses != 1 || dn0 !== 1'b1) begin
      errors++; $display("FAIL stag_drivenext pulses=%0d dn=%b exp=1/1", pulses, dn0);
    end
    tick();
    checks++; if (dn0 !== 1'b0) begin errors++; $display("FAIL stag_drivenext_len got=%b exp=0", dn0); end
    tick();
    f0 = 1'b1;
    checks++; if (free0 !== 16'h0) begin errors++; $display("FAIL stag_free_early got=%h exp=0", free0); end
    tick();
    f0 = 1'b0;
    checks++; if (free0 !== 16'hFFFF || fire0 !== 1'b1) begin
      errors++; $display("FAIL stag_release free=%h fire=%b exp=ffff/1", free0, fire0);
    end
    tick();
    checks++; if (free0 !== 16'h0 || fire0 !== 1'b0 || arr0 !== 16'h0 || dup0 !== 1'b0) begin
      errors++; $display("FAIL stag_after free=%h fire=%b arr=%h dup=%b exp=0/0/0/0", free0, fire0, arr0, dup0);
    end
  endtask

  task automatic test_back_to_back;
    for (int r = 0; r < 4; r++) begin
      d0 = 16'hFFFF;
      tick();
      d0 = '0;
      f0 = 1'b1;
      checks++; if (dn0 !== 1'b1 || arr0 !== 16'hFFFF) begin
        errors++; $display("FAIL b2b_fire round=%0d dn=%b arr=%h exp=1/ffff", r, dn0, arr0);
      end
      tick();
      f0 = 1'b0;
      checks++; if (free0 !== 16'hFFFF || fire0 !== 1'b1 || dn0 !== 1'b0) begin
        errors++; $display("FAIL b2b_release round=%0d free=%h fire=%b dn=%b exp=ffff/1/0", r, free0, fire0, dn0);
      end
      tick();
      checks++; if (free0 !== 16'h0 || arr0 !== 16'h0) begin
        errors++; $display("FAIL b2b_collect round=%0d free=%h arr=%h exp=0/0", r, free0, arr0);
      end
    end
    checks++; if (dup0 !== 1'b0) begin errors++; $display("FAIL b2b_dup got=%b exp=0", dup0); end
  endtask

  task automatic test_disabled_lanes;
    d1 = 16'h0F0F;
    tick();
    checks++; if (arr1 !== 16'h0 || dn1 !== 1'b0) begin
      errors++; $display("FAIL dis_first arr=%h dn=%b exp=0/0", arr1, dn1);
    end
    d1 = 16'h00F0;
    tick();
    checks++; if (arr1 !== 16'h00F0 || dn1 !== 1'b1) begin
      errors++; $display("FAIL dis_fire arr=%h dn=%b exp=00f0/1", arr1, dn1);
    end
    d1 = 16'h0F00;
    f1 = 1'b1;
    tick();
    d1 = '0;
    f1 = 1'b0;
    checks++; if (free1 !== 16'h00F0 || fire1 !== 1'b1) begin
      errors++; $display("FAIL dis_release free=%h fire=%b exp=00f0/1", free1, fire1);
    end
    tick();
    checks++; if (dup1 !== 1'b0 || arr1 !== 16'h0 || free1 !== 16'h0) begin
      errors++; $display("FAIL dis_after dup=%b arr=%h free=%h exp=0/0/0", dup1, arr1, free1);
    end
  endtask

  task automatic test_dup_error;
    d0 = 16'h0008;
    tick();
    checks++; if (dup0 !== 1'b0) begin errors++; $display("FAIL dup_first got=%b exp=0", dup0); end
    tick();
    checks++; if (dup0 !== 1'b1 || arr0 !== 16'h0008) begin
      errors++; $display("FAIL dup_second dup=%b arr=%h exp=1/0008", dup0, arr0);
    end
    d0 = 16'hFFF7;
    tick();
    d0 = '0;
    checks++; if (dn0 !== 1'b1) begin errors++; $display("FAIL dup_fire got=%b exp=1", dn0); end
    tick();
    d0 = 16'h0020;
    tick();
    d0 = '0;
    f0 = 1'b1;
    tick();
    f0 = 1'b0;
    checks++; if (free0 !== 16'hFFFF || dup0 !== 1'b1) begin
      errors++; $display("FAIL dup_release free=%h dup=%b exp=ffff/1", free0, dup0);
    end
    tick();
    checks++; if (arr0[5] !== 1'b0 || dup0 !== 1'b1) begin
      errors++; $display("FAIL dup_after arr5=%b dup=%b exp=0/1", arr0[5], dup0);
    end
  endtask

  task automatic test_timeout;
    int dnSeen;
    dnSeen = 0;
    d2 = 16'h00FF;
    tick();
    d2 = '0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      dnSeen += int'(dn2);
      if (k == 19) begin
        checks++; if (to2 !== 1'b0) begin errors++; $display("FAIL to_early got=%b exp=0", to2); end
      end
      if (k == 20) begin
        checks++; if (to2 !== TO_EXP) begin errors++; $display("FAIL to_hit got=%b exp=%b", to2, TO_EXP); end
      end
    end
    checks++; if (to2 !== TO_EXP || dnSeen != 0) begin
      errors++; $display("FAIL to_sticky to=%b dn_pulses=%0d exp=%b/0", to2, dnSeen, TO_EXP);
    end
  endtask

  task automatic test_mid_reset;
    d0 = 16'hFFFF;
    tick();
    d0 = '0;
    tick();
    checks++; if (st0 !== 2'd2) begin errors++; $display("FAIL mrst_wait state=%0d exp=2", st0); end
    rstn = 1'b0;
    #1;
    checks++; if ({free0, dn0, fire0, arr0, dup0, to0, to2} !== 36'd0 || st0 !== 2'd0) begin
      errors++; $display("FAIL mrst_async outs=%h state=%0d exp=0/0", {free0, dn0, fire0, arr0, dup0, to0, to2}, st0);
    end
    tick();
    rstn = 1'b1;
    tick();
    checks++; if ({free0, dn0, fire0, arr0, dup0, to0, to2} !== 36'd0) begin
      errors++; $display("FAIL mrst_after outs=%h exp=0", {free0, dn0, fire0, arr0, dup0, to0, to2});
    end
    d0 = 16'hFFFF;
    tick();
    d0 = '0;
    f0 = 1'b1;
    checks++; if (dn0 !== 1'b1) begin errors++; $display("FAIL mrst_fire got=%b exp=1", dn0); end
    tick();
    f0 = 1'b0;
    checks++; if (free0 !== 16'hFFFF || fire0 !== 1'b1 || dup0 !== 1'b0) begin
      errors++; $display("FAIL mrst_release free=%h fire=%b dup=%b exp=ffff/1/0", free0, fire0, dup0);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_staggered();
    test_back_to_back();
    test_disabled_lanes();
    test_dup_error();
    test_timeout();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
